// File: rtl/quadra_coef_if.sv
// Byte-stream input and coefficient-table write port of the quadratic coefficient loader.
// The host side (master) drives bytes; the loader (slave) drives the table write.
interface quadra_coef_if #(
  parameter int W = 61
);
  logic         s_valid;
  logic         s_ready;
  logic [7:0]   s_data;
  logic         wr_en;
  logic [6:0]   wr_addr;
  logic [W-1:0] wr_data;

  modport master (
    output s_valid, s_data,
    input  s_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/quadra_coef_loader.sv
// Unpacks framed {c,b,a} coefficient records from a byte stream into 128-entry table writes.
// Define QUADRA_COEF_CRC_EN to require a trailing CRC-8 (poly 0x07) byte on every frame.
module quadra_coef_loader #(
  parameter int A_W = 28,
  parameter int B_W = 20,
  parameter int C_W = 13
) (
  input  logic           clk,
  input  logic           rst,
  quadra_coef_if.slave   bus,
  output logic           busy,
  output logic           commit,
  output logic           err
);
  localparam int W   = A_W + B_W + C_W;
  localparam int RB  = (W + 7) / 8;
  localparam int BCW = $clog2(RB + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_COUNT,
    ST_DATA,
`ifdef QUADRA_COEF_CRC_EN
    ST_CRC,
`endif
    ST_RESP
  } state_t;

  state_t           state, state_nxt;
  logic [6:0]       start_idx;
  logic [7:0]       n_last;
  logic [7:0]       k;
  logic [BCW-1:0]   byte_cnt;
  logic [RB*8-1:0]  rec;
  logic [RB*8-1:0]  rec_next;
  logic             resp_ok;
  logic             accept;
  logic             rec_done;
  logic             last_rec;
  logic             count_bad;

  assign accept    = bus.s_valid && bus.s_ready;
  assign rec_done  = (byte_cnt == BCW'(RB - 1));
  assign last_rec  = (k == n_last);
  assign count_bad = (bus.s_data == 8'd0) || (bus.s_data > 8'd128);
  // Records arrive little-endian: each new byte enters at the top and slides down.
  assign rec_next  = {bus.s_data, rec[RB*8-1:8]};

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: defaulting state_nxt before the case keeps this block free of inferred latches.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept && bus.s_data == 8'hA5) state_nxt = ST_START;
      ST_START: if (accept) state_nxt = ST_COUNT;
      ST_COUNT: if (accept) state_nxt = count_bad ? ST_RESP : ST_DATA;
      ST_DATA: begin
        if (accept && rec_done && last_rec) begin
`ifdef QUADRA_COEF_CRC_EN
          state_nxt = ST_CRC;
`else
          state_nxt = ST_RESP;
`endif
        end
      end
`ifdef QUADRA_COEF_CRC_EN
      ST_CRC:   if (accept) state_nxt = ST_RESP;
`endif
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.s_ready = !rst && (state != ST_RESP);
    busy        = (state != ST_IDLE);
    commit      = (state == ST_RESP) && resp_ok;
    err         = (state == ST_RESP) && !resp_ok;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_idx   <= '0;
      n_last      <= '0;
      k           <= '0;
      byte_cnt    <= '0;
      rec         <= '0;
      resp_ok     <= 1'b0;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
    end else begin
      bus.wr_en <= 1'b0;
      if (accept) begin
        case (state)
          ST_START: start_idx <= bus.s_data[6:0];
          ST_COUNT: begin
            n_last   <= bus.s_data - 8'd1;
            k        <= '0;
            byte_cnt <= '0;
            if (count_bad) resp_ok <= 1'b0;
          end
          ST_DATA: begin
            rec <= rec_next;
            if (rec_done) begin
              byte_cnt    <= '0;
              bus.wr_en   <= 1'b1;
              bus.wr_addr <= start_idx + k[6:0];
              bus.wr_data <= rec_next[W-1:0];
              k           <= k + 8'd1;
`ifndef QUADRA_COEF_CRC_EN
              if (last_rec) resp_ok <= 1'b1;
`endif
            end else begin
              byte_cnt <= byte_cnt + BCW'(1);
            end
          end
`ifdef QUADRA_COEF_CRC_EN
          ST_CRC: resp_ok <= (bus.s_data == crc);
`endif
          default: ;
        endcase
      end
    end
  end

`ifdef QUADRA_COEF_CRC_EN
  logic [7:0] crc;

  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  // The header is excluded: the running CRC restarts whenever IDLE sees a byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= 8'h00;
    end else if (accept) begin
      case (state)
        ST_IDLE:                    crc <= 8'h00;
        ST_START, ST_COUNT, ST_DATA: crc <= crc8_step(crc, bus.s_data);
        default: ;
      endcase
    end
  end
`endif
endmodule

// File: tb/tb_quadra_coef_loader.sv
// Randomized self-checking bench for quadra_coef_loader against a frame-level model.
module tb_quadra_coef_loader;
  localparam int A_W = 28;
  localparam int B_W = 20;
  localparam int C_W = 13;
  localparam int W   = A_W + B_W + C_W;
  localparam int RB  = (W + 7) / 8;
  localparam logic [63:0] MASK = (64'd1 << W) - 64'd1;

  logic clk = 1'b0;
  logic rst;
  logic busy, commit, err;

  always #5 clk = ~clk;

  quadra_coef_if #(.W(W)) bus ();

  quadra_coef_loader #(.A_W(A_W), .B_W(B_W), .C_W(C_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .busy   (busy),
    .commit (commit),
    .err    (err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observed table writes and pulses.
  logic [6:0]  got_addr[$];
  logic [63:0] got_data[$];
  int          n_commit, n_err;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.wr_en) begin
        got_addr.push_back(bus.wr_addr);
        got_data.push_back(64'(bus.wr_data));
      end
      if (commit) n_commit++;
      if (err)    n_err++;
      if (commit || err) check("commit_err_excl", 64'(commit & err), 64'd0);
    end
  end

  logic [7:0] rec_bytes[$];

  task automatic fill_records(input int n);
    rec_bytes.delete();
    repeat (n * RB) rec_bytes.push_back(8'($urandom_range(255, 0)));
  endtask

  // CRC-8 as polynomial division over the message bit stream, MSB first.
  function automatic logic [7:0] model_crc(input logic [7:0] msg[$]);
    logic [7:0] c = 8'h00;
    foreach (msg[i]) begin
      for (int b = 7; b >= 0; b--) begin
        logic fb;
        fb = c[7] ^ msg[i][b];
        c  = c << 1;
        if (fb) c = c ^ 8'h07;
      end
    end
    return c;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap, tries;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (gap) begin
      @(negedge clk);
      bus.s_valid = 1'b0;
    end
    @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_data  = b;
    tries = 0;
    while (!bus.s_ready && tries < 20) begin
      @(negedge clk);
      tries++;
    end
    if (tries >= 20) check("s_ready_timeout", 64'(bus.s_ready), 64'd1);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    bus.s_valid = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic clear_obs();
    got_addr.delete();
    got_data.delete();
    n_commit = 0;
    n_err    = 0;
  endtask

  task automatic run_frame(input string tag, input logic [7:0] start_b, input logic [7:0] count_b,
                           input int max_gap, input logic [7:0] crc_flip);
    logic [7:0]  msg[$];
    logic [6:0]  exp_addr[$];
    logic [63:0] exp_data[$];
    logic [63:0] d;
    bit          ok, good;
    int          n, m;
    clear_obs();
    n  = int'(count_b);
    ok = (n >= 1) && (n <= 128);
    msg.push_back(start_b);
    msg.push_back(count_b);
    if (ok) begin
      for (int i = 0; i < n; i++) begin
        d = 64'd0;
        for (int j = 0; j < RB; j++) begin
          msg.push_back(rec_bytes[i*RB + j]);
          d = d | (64'(rec_bytes[i*RB + j]) << (8 * j));
        end
        exp_addr.push_back(7'((int'(start_b[6:0]) + i) % 128));
        exp_data.push_back(d & MASK);
      end
    end
    good = ok;
    send_byte(8'hA5, max_gap);
    foreach (msg[i]) send_byte(msg[i], max_gap);
`ifdef QUADRA_COEF_CRC_EN
    if (ok) begin
      send_byte(model_crc(msg) ^ crc_flip, max_gap);
      good = (crc_flip == 8'h00);
    end
`endif
    idle(4);
    check({tag, "_wr_cnt"}, 64'(got_addr.size()), 64'(exp_addr.size()));
    m = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
    for (int i = 0; i < m; i++) begin
      check($sformatf("%s_addr%0d", tag, i), 64'(got_addr[i]), 64'(exp_addr[i]));
      check($sformatf("%s_data%0d", tag, i), got_data[i], exp_data[i]);
    end
    check({tag, "_commit"}, 64'(n_commit), good ? 64'd1 : 64'd0);
    check({tag, "_err"},    64'(n_err),    good ? 64'd0 : 64'd1);
    check({tag, "_busy"},   64'(busy),     64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, 64'(bus.s_ready), 64'd0);
    check({tag, "_wr_en"},   64'(bus.wr_en),   64'd0);
    check({tag, "_wr_addr"}, 64'(bus.wr_addr), 64'd0);
    check({tag, "_wr_data"}, 64'(bus.wr_data), 64'd0);
    check({tag, "_busy"},    64'(busy),        64'd0);
    check({tag, "_commit"},  64'(commit),      64'd0);
    check({tag, "_err"},     64'(err),         64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    clear_obs();
    #1;
    check_reset_outputs("rst");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_s_ready", 64'(bus.s_ready), 64'd1);

    // Single record with a known byte pattern.
    rec_bytes.delete();
    for (int i = 1; i <= RB; i++) rec_bytes.push_back(8'(i));
    run_frame("single", 8'h05, 8'd1, 0, 8'h00);

    // Address wrap past 127.
    fill_records(4);
    run_frame("wrap4", 8'd126, 8'd4, 0, 8'h00);
    fill_records(16);
    run_frame("wrap16", 8'd120, 8'd16, 1, 8'h00);

    // Illegal counts.
    run_frame("cnt0",  8'($urandom_range(255, 0)), 8'h00, 0, 8'h00);
    run_frame("cnt81", 8'($urandom_range(255, 0)), 8'h81, 0, 8'h00);
    fill_records(128);
    run_frame("cnt80", 8'($urandom_range(255, 0)), 8'h80, 0, 8'h00);

    // Junk before a header is silently dropped.
    clear_obs();
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    idle(3);
    check("junk_busy",  64'(busy),            64'd0);
    check("junk_wr",    64'(got_addr.size()), 64'd0);
    fill_records(3);
    run_frame("after_junk", 8'($urandom_range(255, 0)), 8'd3, 1, 8'h00);

`ifdef QUADRA_COEF_CRC_EN
    fill_records(5);
    run_frame("crc_bad", 8'($urandom_range(255, 0)), 8'd5, 0, 8'h01);
    run_frame("crc_good", 8'($urandom_range(255, 0)), 8'd5, 0, 8'h00);
`endif

    // Random short frames, with header bytes planted in the payload.
    for (int f = 0; f < 4; f++) begin
      int n;
      n = int'($urandom_range(16, 1));
      fill_records(n);
      rec_bytes[0] = 8'hA5;
      run_frame($sformatf("rand%0d", f), 8'($urandom_range(255, 0)), 8'(n), 2, 8'h00);
    end

    // Full table with throttled input.
    fill_records(128);
    run_frame("full", 8'($urandom_range(255, 0)), 8'd128, 5, 8'h00);

    // Reset during record 3 of 10.
    fill_records(10);
    clear_obs();
    send_byte(8'hA5, 0);
    send_byte(8'd40, 0);
    send_byte(8'd10, 0);
    for (int i = 0; i < 3 * RB + 2; i++) send_byte(rec_bytes[i], 1);
    @(negedge clk);
    bus.s_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    check("midrst_wr_cnt", 64'(got_addr.size()), 64'd3);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    fill_records(10);
    run_frame("post_midrst", 8'd40, 8'd10, 0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
